// File: rtl/mpu_matrix_loader_if.sv
// mpu_matrix_loader_if: command, element stream, matrix and result bundle of the MPU matrix loader.
interface mpu_matrix_loader_if #(parameter int DIM = 5, parameter int ELEM_W = 8);
  logic                      cmd_valid;
  logic [7:0]                cmd_size;
  logic                      cmd_ready;
  logic [ELEM_W-1:0]         in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [0:DIM*DIM*ELEM_W-1] matrix;
  logic [7:0]                size;
  logic                      matrix_valid;
  logic [7:0]                det_result;
  logic [7:0]                res_data;
  logic                      res_valid;
  logic                      res_ready;
  logic                      busy;
  logic                      err_size;
  modport slave (
    input  cmd_valid, cmd_size, in_data, in_valid, det_result, res_ready,
    output cmd_ready, in_ready, matrix, size, matrix_valid, res_data, res_valid, busy, err_size
  );
  modport master (
    output cmd_valid, cmd_size, in_data, in_valid, det_result, res_ready,
    input  cmd_ready, in_ready, matrix, size, matrix_valid, res_data, res_valid, busy, err_size
  );
endinterface

// File: rtl/mpu_matrix_loader.sv
// mpu_matrix_loader: packs a signed element stream into the DIMxDIM matrix bus and returns the determinant.
// Define MPU_LOADER_COLMAJOR_EN to consume the stream column-major instead of row-major.
module mpu_matrix_loader #(
  parameter int DIM         = 5,
  parameter int ELEM_W      = 8,
  parameter int DET_LATENCY = 8
) (
  input logic           clock_i,
  input logic           reset_i,
  mpu_matrix_loader_if.slave bus
);
  localparam int MW = DIM*DIM*ELEM_W;
  localparam int CW = $clog2(DIM+1);
  localparam logic signed [7:0] DIM8 = 8'(DIM);
  localparam logic [7:0] LAST_WAIT = 8'(DET_LATENCY-1);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   row_q, row_d, col_q, col_d;
  logic [7:0]      cnt_q, cnt_d, size_q, size_d, res_q, res_d;
  logic [0:MW-1]   mat_q, mat_d;
  logic            err_q, err_d;
  logic            legal, row_end, col_end;
  logic [CW-1:0]   last;
  int              idx;
  assign legal   = $signed(bus.cmd_size) > 8'sd0 && $signed(bus.cmd_size) <= DIM8;
  assign last    = size_q[CW-1:0] - CW'(1);
  assign row_end = row_q == last;
  assign col_end = col_q == last;
  assign idx     = int'(row_q)*DIM*ELEM_W + int'(col_q)*ELEM_W;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      res_q   <= '0;
      mat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      res_q   <= res_d;
      mat_q   <= mat_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    res_d   = res_q;
    mat_d   = mat_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        if (legal) begin
          size_d  = bus.cmd_size;
          mat_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_LOAD;
        end else err_d = 1'b1;
      end
      S_LOAD: if (bus.in_valid) begin
        mat_d[idx +: ELEM_W] = bus.in_data;
        if (row_end && col_end) begin
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
`ifdef MPU_LOADER_COLMAJOR_EN
          row_d = row_end ? '0 : row_q + CW'(1);
          col_d = row_end ? col_q + CW'(1) : col_q;
`else
          col_d = col_end ? '0 : col_q + CW'(1);
          row_d = col_end ? row_q + CW'(1) : row_q;
`endif
        end
      end
      S_WAIT: if (cnt_q == LAST_WAIT) begin
        res_d   = bus.det_result;
        state_d = S_DONE;
      end else cnt_d = cnt_q + 8'd1;
      S_DONE: if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign bus.cmd_ready    = state_q == S_IDLE;
  assign bus.in_ready     = state_q == S_LOAD;
  assign bus.matrix_valid = state_q == S_WAIT;
  assign bus.res_valid    = state_q == S_DONE;
  assign bus.busy         = state_q != S_IDLE;
  assign bus.err_size     = err_q;
  assign bus.matrix       = mat_q;
  assign bus.size         = size_q;
  assign bus.res_data     = res_q;
endmodule

// File: doc/mpu_matrix_loader.md
Name: mpu_matrix_loader

Overview:
- Upstream feeder for the MPU determinant stage.
- Accepts a size command and a row-major byte stream of signed 8-bit elements, then packs them into the flat 5x5 matrix bus.
- Holds the matrix and size stable while the determinant stage computes, captures its 8-bit result after a fixed latency, and returns it over a valid/ready handshake.

Parameters:
- DIM, 5, maximum matrix dimension; matrix bus width is DIM*DIM*ELEM_W.
- ELEM_W, 8, element width in bits; elements are signed.
- DET_LATENCY, 8, cycles from matrix_valid rising until det_result is sampled; legal range 1..255.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  start request, sampled only in IDLE.
- cmd_size  in  8  signed matrix size; legal values are 1..DIM.
- cmd_ready  out  1  high in IDLE.
- in_data  in  8  signed element, row-major order.
- in_valid  in  1  element valid.
- in_ready  out  1  high in LOAD.
- matrix  out  200  packed matrix, ascending [0:199]; element (r,c) occupies bits [r*40+c*8 +: 8].
- size  out  8  latched size, drives the determinant stage.
- matrix_valid  out  1  high in WAIT.
- det_result  in  8  signed determinant from the downstream stage.
- res_data  out  8  captured determinant.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- busy  out  1  high in any state other than IDLE.
- err_size  out  1  one-cycle pulse when a command with an illegal size is rejected.

Behaviour:
- Reset (synchronous, clock and reset as named above):
  - state goes to IDLE.
  - matrix, size, res_data, the element counters and the wait counter all clear to 0.
  - cmd_ready goes to 1; in_ready, matrix_valid, res_valid, busy and err_size go to 0.
- Reset has priority over every other event in the same cycle. It aborts LOAD, WAIT or DONE mid-operation with no partial output.
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - When cmd_valid is 1 and cmd_size is in 1..DIM: latch size, clear matrix to 0, zero the row and column counters, go to LOAD.
  - When cmd_valid is 1 and cmd_size is illegal (<=0 or >DIM): pulse err_size for one cycle and stay in IDLE.
- LOAD:
  - Each cycle with in_valid and in_ready both high writes in_data to element (row,col), then increments col.
  - When col reaches size-1, col wraps to 0 and row increments.
  - The element that completes (size-1,size-1) moves the FSM to WAIT on the next edge, with matrix updated on that same edge.
  - Elements outside the size x size window stay 0.
  - cmd_valid is ignored in this state.
- WAIT:
  - matrix_valid is 1; matrix and size are held constant.
  - The wait counter counts from 0. In the cycle where the counter equals DET_LATENCY-1, det_result is registered into res_data and the FSM moves to DONE.
  - Total: matrix_valid stays high for exactly DET_LATENCY cycles.
- DONE:
  - res_valid is 1; res_data, matrix and size are held.
  - When res_valid and res_ready are both high, go to IDLE; res_valid drops on the next edge.
- Back-to-back: a new command is accepted no earlier than the first IDLE cycle. Command-to-first-element acceptance takes at least 1 cycle.
- Arithmetic: no width growth. res_data is the 8-bit value from the downstream stage, passed through unmodified; wrap-around is owned downstream.

Optional Feature:
- Macro: MPU_LOADER_COLMAJOR_EN.
- Defined: LOAD consumes the stream column-major. row increments first; on reaching size-1 it wraps to 0 and col increments. The stream therefore fills the transpose order, while the packed layout on matrix is unchanged.
- Undefined: row-major as specified above.
- The determinant value is identical either way for a transposed stream.

Test Plan:
- Size 1: cmd_size=1, stream {7}, downstream det_result=7 -> matrix[0:7]=7, all other bits 0; matrix_valid high 8 cycles; res_data=7; res_valid holds until res_ready.
- Size 2: stream {3,1,2,4}, det_result tied to 8'sd10 -> element (1,0)=2 at bits [40+:8]; element (1,1)=4 at bits [48+:8]; res_data=10.
- Size 5 with in_valid toggling every other cycle: stream 1..25 -> element (4,4)=25 at bits [192+:8]; WAIT is entered only after the 25th beat; in_ready stays high throughout LOAD.
- Illegal sizes: cmd_size=0, then 6, then -1 -> err_size pulses three times; state stays IDLE; busy=0.
- Reset mid-operation: reset asserted during LOAD after 4 of 9 elements (size 3), and again during WAIT -> next cycle all outputs are at reset values; a subsequent size-2 command completes normally.
- Backpressure in DONE: res_ready=0 for 10 cycles -> res_data stable; cmd_ready=0; cmd_valid ignored; after res_ready=1, IDLE is reached the next cycle.
